// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb_pkg
//  Purpose  : Shared defaults for the register file and the CPU core:
//             data/index widths, the hardwired-zero register index and the
//             byte-lane count helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_sb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_IDX   = 0;

    // Number of 8-bit lanes in a data word.
    function automatic int lane_count(input int width);
        return width / 8;
    endfunction

endpackage : regfile_sb_pkg
`default_nettype wire

// File: rtl/regfile_sb_bypass.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb_bypass
//  Purpose  : One read-port view of the register file. Detects a same-cycle
//             writeback to the addressed register and merges the enabled
//             byte lanes of the write data over the stored word.
//  Ports    : stored_i  - word currently held in the array at ra_i
//             ra_i      - read index
//             we_i/wa_i - writeback valid / index
//             wbe_i     - byte-lane enables of the writeback
//             wd_i      - writeback data
//             data_o    - merged (or plain stored) read data
//             hit_o     - writeback targets this read index this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb_bypass
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic [DATA_W-1:0]   stored_i,
    input  logic [ADDR_W-1:0]   ra_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   wa_i,
    input  logic [DATA_W/8-1:0] wbe_i,
    input  logic [DATA_W-1:0]   wd_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                hit_o
);

    localparam int NLANE = lane_count(DATA_W);

    always_comb begin
        hit_o  = (BYPASS != 0) && we_i && (wa_i == ra_i);
        data_o = stored_i;
        if (hit_o) begin
            for (int k = 0; k < NLANE; k++) begin
                if (wbe_i[k]) begin
                    data_o[8*k +: 8] = wd_i[8*k +: 8];
                end
            end
        end
    end

endmodule : regfile_sb_bypass
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : 2-read/1-write register file with byte-lane writes, optional
//             write-to-read bypass, optional hardwired zero register and a
//             per-register busy scoreboard with a registered busy count.
//  Ports    : clk, res (sync, active-low)
//             ra1/ra2 -> rd1/rd2, rbusy1/rbusy2 (combinational reads)
//             we, wa, wbe, wd    writeback port (clears busy)
//             iss_v, iss_a       issue port (sets busy)
//             busy_cnt           registered popcount of the busy bits
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                res,
    input  logic [ADDR_W-1:0]   ra1,
    input  logic [ADDR_W-1:0]   ra2,
    output logic [DATA_W-1:0]   rd1,
    output logic [DATA_W-1:0]   rd2,
    output logic                rbusy1,
    output logic                rbusy2,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wa,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [DATA_W-1:0]   wd,
    input  logic                iss_v,
    input  logic [ADDR_W-1:0]   iss_a,
    output logic [ADDR_W:0]     busy_cnt
);

    localparam int              NREG  = 2**ADDR_W;
    localparam int              NLANE = lane_count(DATA_W);
    localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_IDX);

    generate
        if (DATA_W % 8 != 0) begin : g_bad_width
            $error("regfile_sb: DATA_W must be a multiple of 8");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // Events with the zero register filtered out; these drive all state.
    logic we_g, iss_g, set_ev, clr_ev;
    assign we_g  = we    && !((ZERO_REG != 0) && (wa    == ZIDX));
    assign iss_g = iss_v && !((ZERO_REG != 0) && (iss_a == ZIDX));

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!res) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_g) begin
            for (int k = 0; k < NLANE; k++) begin
                if (wbe[k]) begin
                    mem_q[wa][8*k +: 8] <= wd[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: clear on writeback, then set on issue so that a new
    // producer issued in the retiring cycle keeps the register busy.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (we_g) begin
            busy_d[wa] = 1'b0;
        end
        if (iss_g) begin
            busy_d[iss_a] = 1'b1;
        end
    end

    // Count only real 0->1 and 1->0 transitions so busy_cnt tracks the
    // popcount without having to sum the whole vector.
    always_comb begin
        set_ev = iss_g && !busy_q[iss_a];
        clr_ev = we_g && busy_q[wa] && !(iss_g && (iss_a == wa));
        cnt_d  = cnt_q + (ADDR_W+1)'(set_ev) - (ADDR_W+1)'(clr_ev);
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] byp_d1, byp_d2;
    logic              hit1, hit2;
    logic              zr1, zr2, iss_same;

    regfile_sb_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_byp1 (
        .stored_i (mem_q[ra1]),
        .ra_i     (ra1),
        .we_i     (we),
        .wa_i     (wa),
        .wbe_i    (wbe),
        .wd_i     (wd),
        .data_o   (byp_d1),
        .hit_o    (hit1)
    );

    regfile_sb_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_byp2 (
        .stored_i (mem_q[ra2]),
        .ra_i     (ra2),
        .we_i     (we),
        .wa_i     (wa),
        .wbe_i    (wbe),
        .wd_i     (wd),
        .data_o   (byp_d2),
        .hit_o    (hit2)
    );

    assign zr1      = (ZERO_REG != 0) && (ra1 == ZIDX);
    assign zr2      = (ZERO_REG != 0) && (ra2 == ZIDX);
    // A same-cycle reissue of the retiring register keeps it busy.
    assign iss_same = iss_v && (iss_a == wa);

    always_comb begin
        rd1    = zr1 ? '0 : byp_d1;
        rd2    = zr2 ? '0 : byp_d2;
        rbusy1 = !zr1 && !(hit1 && !iss_same) && busy_q[ra1];
        rbusy2 = !zr2 && !(hit2 && !iss_same) && busy_q[ra2];
    end

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb (default parameters:
//             32-bit data, 32 registers, zero register, bypass enabled).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic        clk;
    logic        res;
    logic [4:0]  ra1, ra2, wa, iss_a;
    logic [31:0] rd1, rd2, wd;
    logic        rbusy1, rbusy2, we, iss_v;
    logic [3:0]  wbe;
    logic [5:0]  busy_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: plain arrays of register contents and busy flags.
    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    regfile_sb dut (
        .clk      (clk),
        .res      (res),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .rbusy1   (rbusy1),
        .rbusy2   (rbusy2),
        .we       (we),
        .wa       (wa),
        .wbe      (wbe),
        .wd       (wd),
        .iss_v    (iss_v),
        .iss_a    (iss_a),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] ra);
        logic [31:0] r;
        if (ra == 5'd0) return 32'd0;
        r = m_mem[ra];
        if (we && wa == ra)
            for (int k = 0; k < 4; k++)
                if (wbe[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    function automatic logic m_rbusy(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        if (we && wa == ra && !(iss_v && iss_a == wa)) return 1'b0;
        return m_busy[ra];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic idle();
        we = 0; iss_v = 0; wbe = 4'h0; wd = '0; wa = '0; iss_a = '0;
    endtask

    // Check combinational outputs for the inputs currently applied.
    task automatic comb_chk();
        #1;
        chk("rd1",    {32'd0, rd1},   {32'd0, m_rd(ra1)});
        chk("rd2",    {32'd0, rd2},   {32'd0, m_rd(ra2)});
        chk("rbusy1", {63'd0, rbusy1}, {63'd0, m_rbusy(ra1)});
        chk("rbusy2", {63'd0, rbusy2}, {63'd0, m_rbusy(ra2)});
    endtask

    // Clock edge: advance the reference model, then check busy_cnt.
    task automatic tick();
        @(posedge clk);
        if (!res) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && wa != 5'd0) begin
                for (int k = 0; k < 4; k++)
                    if (wbe[k]) m_mem[wa][8*k +: 8] = wd[8*k +: 8];
                m_busy[wa] = 1'b0;
            end
            if (iss_v && iss_a != 5'd0) m_busy[iss_a] = 1'b1;
        end
        #1;
        chk("busy_cnt", {58'd0, busy_cnt}, 64'(m_count()));
        @(negedge clk);
    endtask

    task automatic step();
        comb_chk();
        tick();
    endtask

    initial begin
        idle();
        ra1 = '0; ra2 = '0;
        res = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0; m_busy[i] = 1'b0;
        end
        res = 1'b1;

        // Reset clears a written register.
        we = 1; wa = 5; wbe = 4'hF; wd = 32'hDEADBEEF; ra1 = 5; ra2 = 5;
        step();
        idle(); res = 1'b0;
        step();
        res = 1'b1;
        comb_chk();
        chk("rst_rd1",    {32'd0, rd1},    64'd0);
        chk("rst_rbusy1", {63'd0, rbusy1}, 64'd0);
        chk("rst_cnt",    {58'd0, busy_cnt}, 64'd0);
        tick();

        // Byte-lane writes, bypassed and stored.
        we = 1; wa = 3; wbe = 4'hF; wd = 32'h11223344; ra1 = 3; ra2 = 3;
        step();
        wbe = 4'b0101; wd = 32'hAABBCCDD;
        comb_chk();
        chk("be_bypass", {32'd0, rd1}, 64'h11BB33DD);
        tick();
        idle();
        comb_chk();
        chk("be_stored", {32'd0, rd2}, 64'h11BB33DD);
        tick();

        // Zero register ignores writes and issues.
        we = 1; wa = 0; wbe = 4'hF; wd = 32'hFFFFFFFF; iss_v = 1; iss_a = 0; ra1 = 0; ra2 = 0;
        comb_chk();
        chk("zero_rd",    {32'd0, rd1},    64'd0);
        chk("zero_rbusy", {63'd0, rbusy1}, 64'd0);
        tick();
        chk("zero_cnt", {58'd0, busy_cnt}, 64'd0);

        // Scoreboard set / bypassed clear.
        idle(); iss_v = 1; iss_a = 7; step();
        iss_a = 9; step();
        idle(); ra1 = 7; ra2 = 9;
        comb_chk();
        chk("sb_cnt2",   {58'd0, busy_cnt}, 64'd2);
        chk("sb_busy7",  {63'd0, rbusy1},   64'd1);
        tick();
        we = 1; wa = 7; wbe = 4'hF; wd = 32'hCAFE0007;
        comb_chk();
        chk("sb_wb_rbusy", {63'd0, rbusy1}, 64'd0);
        chk("sb_wb_rd",    {32'd0, rd1},    64'hCAFE0007);
        tick();
        chk("sb_cnt1", {58'd0, busy_cnt}, 64'd1);

        // Simultaneous issue and writeback to a busy register.
        idle(); iss_v = 1; iss_a = 4; step();
        we = 1; wa = 4; wbe = 4'hF; wd = 32'h44; iss_v = 1; iss_a = 4; ra1 = 4;
        comb_chk();
        chk("simul_rbusy", {63'd0, rbusy1}, 64'd1);
        tick();
        chk("simul_cnt", {58'd0, busy_cnt}, 64'd2);

        // Reset mid-operation drops pending marks.
        idle(); res = 1'b0; step();
        res = 1'b1;
        iss_v = 1; iss_a = 2; step();
        iss_a = 6; step();
        idle(); ra1 = 2; ra2 = 6;
        comb_chk();
        chk("mid_cnt2", {58'd0, busy_cnt}, 64'd2);
        res = 1'b0;
        tick();
        res = 1'b1;
        chk("mid_cnt0", {58'd0, busy_cnt}, 64'd0);
        we = 1; wa = 2; wbe = 4'hF; wd = 32'h5;
        step();
        idle();
        comb_chk();
        chk("mid_r2",   {32'd0, rd1},      64'd5);
        chk("mid_cnt",  {58'd0, busy_cnt}, 64'd0);
        tick();

        // Randomized traffic concentrated on a few registers for collisions.
        for (int n = 0; n < 400; n++) begin
            res   = ($urandom_range(0, 49) != 0);
            we    = $urandom_range(0, 1) == 1;
            iss_v = $urandom_range(0, 9) < 4;
            wbe   = 4'($urandom_range(0, 15));
            wd    = $urandom;
            wa    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            iss_a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ra1   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
            ra2   = ($urandom_range(0, 2) == 0) ? iss_a : 5'($urandom_range(0, 31));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
